// File: rtl/multicycle_main_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_main_control
// Purpose  : Main control FSM for the multi-cycle RV32I core; optional
//            memory wait-state support is enabled with MEM_WAIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_main_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSource,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUop,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0]       c_OP_R     = 7'b0110011;
    localparam logic [6:0]       c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0]       c_OP_STORE = 7'b0100011;
    localparam logic [6:0]       c_OP_BEQ   = 7'b1100011;
    localparam logic [CNT_W-1:0] c_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_retire;
    logic             w_ready;
    logic             r_illegal;
    logic [CNT_W-1:0] r_instret;

`ifdef MEM_WAIT_EN
    assign w_ready = mem_ready;
`else
    // Without wait-state support every memory access completes in one cycle.
    logic w_unused_mem_ready;
    assign w_ready            = 1'b1;
    assign w_unused_mem_ready = mem_ready;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_instret <= r_instret + c_ONE;
            end
            if (w_next == S_HALT) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign instret = reset ? '0 : r_instret;

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        mem_req  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSource = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUop    = 2'b00;
        RegWrite = 1'b0;
        MemtoReg = 1'b0;
        illegal  = 1'b0;

        // Reset silences every strobe, even before the state register settles.
        if (!reset) begin
            illegal = r_illegal;
            unique case (r_state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = w_ready;
                    PCWrite = w_ready;
                    if (w_ready) begin
                        w_next = S_DECODE;
                    end
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    case (opcode)
                        c_OP_R:                 w_next = S_EXEC;
                        c_OP_LOAD, c_OP_STORE:  w_next = S_MEMADR;
                        c_OP_BEQ:               w_next = S_BRANCH;
                        default:                w_next = S_HALT;
                    endcase
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    case (opcode)
                        c_OP_LOAD:  w_next = S_MEMRD;
                        c_OP_STORE: w_next = S_MEMWR;
                        default:    w_next = S_HALT;
                    endcase
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    if (w_ready) begin
                        w_next = S_MEMWB;
                    end
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
                S_MEMWR: begin
                    mem_req  = 1'b1;
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    if (w_ready) begin
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUop   = 2'b10;
                    w_next  = S_ALUWB;
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
                S_BRANCH: begin
                    ALUSrcA  = 1'b1;
                    ALUop    = 2'b01;
                    PCSource = 1'b1;
                    PCWrite  = zero;
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
                S_HALT: begin
                    w_next = S_HALT;
                end
                default: begin
                    w_next = S_FETCH;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_main_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_main_control
// Purpose  : Directed self-checking bench for multicycle_main_control
//            (CNT_W=4); expectations follow MEM_WAIT_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_main_control;

    localparam int CNT_W = 4;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    // {mem_req,MemRead,MemWrite,IorD,IRWrite,PCWrite,PCSource,ALUSrcA,
    //  ALUSrcB,ALUop,RegWrite,MemtoReg,illegal}
    localparam logic [14:0] E_ZERO   = 15'd0;
    localparam logic [14:0] E_FETCH  = {1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0};
    localparam logic [14:0] E_FWAIT  = {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0};
    localparam logic [14:0] E_DECODE = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,1'b0,1'b0,1'b0};
    localparam logic [14:0] E_MEMADR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0};
    localparam logic [14:0] E_MEMRD  = {1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0};
    localparam logic [14:0] E_MEMWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,1'b1,1'b0};
    localparam logic [14:0] E_MEMWR  = {1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0};
    localparam logic [14:0] E_EXEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,1'b0,1'b0,1'b0};
    localparam logic [14:0] E_ALUWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,1'b0,1'b0};
    localparam logic [14:0] E_BR_T   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,2'b00,2'b01,1'b0,1'b0,1'b0};
    localparam logic [14:0] E_BR_N   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,2'b01,1'b0,1'b0,1'b0};
    localparam logic [14:0] E_HALT   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b1};

    logic             clk = 1'b0;
    logic             reset;
    logic [6:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource, ALUSrcA;
    logic [1:0]       ALUSrcB, ALUop;
    logic             RegWrite, MemtoReg, illegal;
    logic [CNT_W-1:0] instret;
    logic [14:0]      ctl;

    int               total = 0;
    int               bad   = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    always #5 clk = ~clk;

    assign ctl = {mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource, ALUSrcA,
                  ALUSrcB, ALUop, RegWrite, MemtoReg, illegal};

    multicycle_main_control #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .IorD      (IorD),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .PCSource  (PCSource),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUop     (ALUop),
        .RegWrite  (RegWrite),
        .MemtoReg  (MemtoReg),
        .illegal   (illegal),
        .instret   (instret)
    );

    // Each task begins mid-cycle in FETCH and ends mid-cycle in FETCH.
    task automatic test_reset();
        reset = 1'b1; opcode = OP_R; zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if (ctl !== E_ZERO) begin
                bad++; $display("FAIL reset_ctl cyc%0d got=%b want=%b", i, ctl, E_ZERO);
            end
            total++;
            if (instret !== 4'd0) begin
                bad++; $display("FAIL reset_instret cyc%0d got=%0d want=0", i, instret);
            end
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        total++;
        if (ctl !== E_FETCH) begin
            bad++; $display("FAIL reset_release_fetch got=%b want=%b", ctl, E_FETCH);
        end
        total++;
        if (instret !== 4'd0) begin
            bad++; $display("FAIL reset_release_instret got=%0d want=0", instret);
        end
        exp_cnt = '0;
    endtask

    task automatic test_rtype();
        logic [14:0] es [4];
        es = '{E_FETCH, E_DECODE, E_EXEC, E_ALUWB};
        for (int i = 0; i < 4; i++) begin
            opcode = OP_R; mem_ready = 1'b1;
            #1;
            total++;
            if (ctl !== es[i]) begin
                bad++; $display("FAIL rtype_ctl cyc%0d got=%b want=%b", i, ctl, es[i]);
            end
            @(negedge clk);
        end
        exp_cnt = exp_cnt + 4'd1;
        #1;
        total++;
        if (instret !== exp_cnt) begin
            bad++; $display("FAIL rtype_instret got=%0d want=%0d", instret, exp_cnt);
        end
    endtask

    task automatic test_load();
`ifdef MEM_WAIT_EN
        logic [14:0] es  [7];
        logic        rdy [7];
        es  = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMWB};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
`else
        logic [14:0] es  [5];
        logic        rdy [5];
        es  = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
        for (int i = 0; i < $size(es); i++) begin
            opcode = OP_LOAD; mem_ready = rdy[i];
            #1;
            total++;
            if (ctl !== es[i]) begin
                bad++; $display("FAIL load_ctl cyc%0d got=%b want=%b", i, ctl, es[i]);
            end
            @(negedge clk);
        end
        exp_cnt = exp_cnt + 4'd1;
        mem_ready = 1'b1;
        #1;
        total++;
        if (ctl !== E_FETCH) begin
            bad++; $display("FAIL load_back_to_fetch got=%b want=%b", ctl, E_FETCH);
        end
        total++;
        if (instret !== exp_cnt) begin
            bad++; $display("FAIL load_instret got=%0d want=%0d", instret, exp_cnt);
        end
    endtask

    task automatic test_store();
`ifdef MEM_WAIT_EN
        logic [14:0] es  [6];
        logic        rdy [6];
        es  = '{E_FWAIT, E_FETCH, E_DECODE, E_MEMADR, E_MEMWR, E_MEMWR};
        rdy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`else
        logic [14:0] es  [4];
        logic        rdy [4];
        es  = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR};
        rdy = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < $size(es); i++) begin
            opcode = OP_STORE; mem_ready = rdy[i];
            #1;
            total++;
            if (ctl !== es[i]) begin
                bad++; $display("FAIL store_ctl cyc%0d got=%b want=%b", i, ctl, es[i]);
            end
            @(negedge clk);
        end
        exp_cnt = exp_cnt + 4'd1;
        mem_ready = 1'b1;
        #1;
        total++;
        if (instret !== exp_cnt) begin
            bad++; $display("FAIL store_instret got=%0d want=%0d", instret, exp_cnt);
        end
    endtask

    task automatic test_branch();
        logic [14:0] es [6];
        logic        zz [6];
        es = '{E_FETCH, E_DECODE, E_BR_T, E_FETCH, E_DECODE, E_BR_N};
        zz = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            opcode = OP_BEQ; mem_ready = 1'b1; zero = zz[i];
            #1;
            total++;
            if (ctl !== es[i]) begin
                bad++; $display("FAIL branch_ctl cyc%0d got=%b want=%b", i, ctl, es[i]);
            end
            @(negedge clk);
        end
        exp_cnt = exp_cnt + 4'd2;
        zero = 1'b0;
        #1;
        total++;
        if (instret !== exp_cnt) begin
            bad++; $display("FAIL branch_instret got=%0d want=%0d", instret, exp_cnt);
        end
    endtask

    task automatic test_illegal();
        logic [14:0] es [2];
        es = '{E_FETCH, E_DECODE};
        for (int i = 0; i < 2; i++) begin
            opcode = OP_BAD; mem_ready = 1'b1;
            #1;
            total++;
            if (ctl !== es[i]) begin
                bad++; $display("FAIL illegal_ctl cyc%0d got=%b want=%b", i, ctl, es[i]);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 10; i++) begin
            mem_ready = i[0];
            opcode    = (i < 5) ? OP_R : OP_LOAD;
            #1;
            total++;
            if (ctl !== E_HALT) begin
                bad++; $display("FAIL halt_ctl cyc%0d got=%b want=%b", i, ctl, E_HALT);
            end
            total++;
            if (instret !== exp_cnt) begin
                bad++; $display("FAIL halt_instret cyc%0d got=%0d want=%0d", i, instret, exp_cnt);
            end
            @(negedge clk);
        end
        reset = 1'b1; mem_ready = 1'b1;
        #1;
        total++;
        if (ctl !== E_ZERO) begin
            bad++; $display("FAIL halt_reset_ctl got=%b want=%b", ctl, E_ZERO);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = '0;
        #1;
        total++;
        if (ctl !== E_FETCH) begin
            bad++; $display("FAIL halt_release_fetch got=%b want=%b", ctl, E_FETCH);
        end
        total++;
        if (instret !== exp_cnt) begin
            bad++; $display("FAIL halt_release_instret got=%0d want=%0d", instret, exp_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [14:0] es [4];
        es = '{E_FETCH, E_DECODE, E_EXEC, E_ALUWB};
        for (int n = 0; n < 17; n++) begin
            for (int i = 0; i < 4; i++) begin
                opcode = OP_R; mem_ready = 1'b1;
                #1;
                total++;
                if (ctl !== es[i]) begin
                    bad++; $display("FAIL wrap_ctl instr%0d cyc%0d got=%b want=%b", n, i, ctl, es[i]);
                end
                @(negedge clk);
            end
        end
        #1;
        total++;
        if (instret !== 4'd1) begin
            bad++; $display("FAIL wrap_instret got=%0d want=1", instret);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load();
        test_store();
        test_branch();
        test_illegal();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/multicycle_main_control.md
# multicycle_main_control

Main control FSM for the multi-cycle RV32I core. It decodes the 7-bit opcode of the fetched instruction and sequences the datapath through fetch, decode, execute, memory and writeback cycles. It produces the 2-bit `ALUop` that the downstream ALU-control decoder turns into a 4-bit ALU operation. It also drives all datapath strobes, waits on a memory ready handshake, counts retired instructions and flags unsupported opcodes.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `opcode`, input, 7: `IR[6:0]`; sampled only in DECODE and MEMADR.
- `zero`, input, 1: ALU zero flag; used in BRANCH.
- `mem_ready`, input, 1: memory completes the current request this cycle.
- `mem_req`, output, 1: memory request valid.
- `MemRead`, output, 1: memory read strobe.
- `MemWrite`, output, 1: memory write strobe.
- `IorD`, output, 1: memory address select; 0 selects PC, 1 selects ALUOut.
- `IRWrite`, output, 1: instruction register load.
- `PCWrite`, output, 1: PC load. Already qualified with `mem_ready` in FETCH and with `zero` in BRANCH.
- `PCSource`, output, 1: next-PC select; 0 selects the ALU result, 1 selects ALUOut.
- `ALUSrcA`, output, 1: ALU A input select; 0 selects PC, 1 selects rs1.
- `ALUSrcB`, output, 2: ALU B input select. 00 = rs2, 01 = constant 4, 10 = I/S immediate, 11 = B immediate.
- `ALUop`, output, 2: 00 = add, 01 = sub/compare, 10 = funct-decoded.
- `RegWrite`, output, 1: register file write.
- `MemtoReg`, output, 1: writeback select; 0 selects ALUOut, 1 selects MDR.
- `illegal`, output, 1: sticky flag for an unsupported opcode.
- `instret`, output, `CNT_W`: retired-instruction count.

Clock is `clk`. Reset is synchronous and active-high on `reset`.

## Operation
Supported opcodes:
- R-type `0110011`
- load `0000011`
- store `0100011`
- beq `1100011`

All other opcodes go to HALT.

States, with the outputs asserted in each. Any output not listed is 0.
- **FETCH**: `mem_req`, `MemRead`, `IorD=0`, `ALUSrcA=0`, `ALUSrcB=01`, `ALUop=00`.
  - `IRWrite` and `PCWrite` equal `mem_ready`.
  - Go to DECODE when `mem_ready`; otherwise stay.
- **DECODE**: `ALUSrcA=0`, `ALUSrcB=11`, `ALUop=00` (branch target into ALUOut).
  - R-type → EXEC; load or store → MEMADR; beq → BRANCH; other → HALT.
- **MEMADR**: `ALUSrcA=1`, `ALUSrcB=10`, `ALUop=00`.
  - load → MEMRD; store → MEMWR.
- **MEMRD**: `mem_req`, `MemRead`, `IorD=1`.
  - Go to MEMWB on `mem_ready`; otherwise stay.
- **MEMWB**: `RegWrite`, `MemtoReg=1` → FETCH.
- **MEMWR**: `mem_req`, `MemWrite`, `IorD=1`.
  - Go to FETCH on `mem_ready`; otherwise stay.
- **EXEC**: `ALUSrcA=1`, `ALUSrcB=00`, `ALUop=10` → ALUWB.
- **ALUWB**: `RegWrite`, `MemtoReg=0` → FETCH.
- **BRANCH**: `ALUSrcA=1`, `ALUSrcB=00`, `ALUop=01`, `PCSource=1`, `PCWrite=zero` → FETCH.
- **HALT**: all strobes 0, `illegal=1`. Stays in HALT until `reset`.

Retirement:
- `instret` increments by 1 on the edge leaving MEMWB, ALUWB or BRANCH, and on the edge leaving MEMWR when `mem_ready`=1.
- `instret` wraps modulo 2^`CNT_W`.

Handshake rules:
- `mem_req` and the address/strobe outputs are held stable until the cycle in which `mem_ready`=1.
- `mem_ready` is ignored outside FETCH, MEMRD and MEMWR.

## Timing
- Outputs are Moore-decoded from the state register. The exceptions are `PCWrite` and `IRWrite`, which also depend combinationally on `mem_ready` and `zero`.
- Zero-wait-state instruction latency: R-type 4 cycles, load 5, store 4, beq 3. Each cycle with `mem_ready`=0 during a memory access adds 1 cycle.
- While `reset`=1: every output is 0, including `mem_req`, `illegal` and `instret`.
- On the first edge with `reset`=1: state becomes FETCH, `instret` becomes 0, `illegal` becomes 0.
- Reset asserted mid-instruction aborts the instruction: no retirement count and no further strobes.
- The first cycle after `reset` deasserts is FETCH with `mem_req`=1.

## Configuration
- `MEM_WAIT_EN` defined:
  - `mem_ready` is honoured as described above.
- `MEM_WAIT_EN` undefined:
  - `mem_ready` is internally forced to 1.
  - FETCH, MEMRD and MEMWR each last exactly 1 cycle.
  - The `mem_ready` port remains but is unused.

## Test plan
- **Reset:** hold `reset` for 2 cycles, then release with `mem_ready`=1. During reset all outputs are 0. The first cycle after release is FETCH with `mem_req`=1, `PCWrite`=1, `IRWrite`=1 and `instret`=0.
- **R-type:** opcode `0110011`, `mem_ready`=1. Sequence is FETCH, DECODE, EXEC (`ALUop`=10), ALUWB (`RegWrite`=1). `instret` is 1 after 4 cycles.
- **Load with wait states:** opcode `0000011`, `mem_ready` low for 2 cycles in MEMRD. `mem_req`, `MemRead` and `IorD`=1 are held for 3 cycles. Then MEMWB with `MemtoReg`=1 and `RegWrite`=1; total 7 cycles.
- **Branch:** beq with `zero`=1, then beq with `zero`=0. In BRANCH `ALUop`=01. `PCWrite` is 1 for the first and 0 for the second; each takes 3 cycles and `instret` advances by 2.
- **Illegal opcode:** opcode `1111111`. DECODE goes to HALT and `illegal`=1. Toggling `mem_ready` for 10 cycles produces no strobe. Asserting `reset` clears `illegal` and returns to FETCH.
- **Counter wrap:** with `CNT_W`=4, run 17 R-type instructions. `instret` reads 1.
- **Build without `MEM_WAIT_EN`:** hold `mem_ready`=0. A store still completes in 4 cycles.
